// File: rtl/fir_pkg.sv
// Shared FIR datapath helpers: width/latency derivations and the tag type
// carried alongside multiplier products.
package fir_pkg;

  // Latency of the 2x2 leaf multiplier at the bottom of the recursive multiplier.
  localparam int BASE_MUL_LATENCY = 1;

  // Operand width used when a block is not given its own.
  localparam int DEFAULT_BITWIDTH_INPUT = 16;

  // Tag that travels through the delay line next to the multiplier.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Sum width: one full product plus headroom for every tap of a sample.
  function automatic int acc_width(input int bitwidth, input int num_taps);
    return 2 * bitwidth + clog2(num_taps);
  endfunction

  // Each recursion level above 2 bits adds two register stages.
  function automatic int mul_latency(input int bitwidth);
    int levels;
    levels = clog2(bitwidth) - 1;
    return ((levels > 0) ? 2 * levels : 0) + BASE_MUL_LATENCY;
  endfunction

endpackage

// File: rtl/fir_tap_accumulator_if.sv
// Tap issue / product / finished-sum signals between the FIR tap accumulator
// and its neighbours (tap sequencer, multiplier, downstream consumer).
interface fir_tap_accumulator_if
  import fir_pkg::*;
#(
  parameter int BITWIDTH_INPUT = DEFAULT_BITWIDTH_INPUT,
  parameter int NUM_TAPS       = 8
);
  localparam int ACC_WIDTH = acc_width(BITWIDTH_INPUT, NUM_TAPS);

  logic                        in_valid;
  logic                        in_last;
  logic                        in_ready;
  logic [2*BITWIDTH_INPUT-1:0] q;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_WIDTH-1:0]        out_sum;
  logic                        tap_err;

  modport master (
    output in_valid, in_last, q, out_ready,
    input  in_ready, out_valid, out_sum, tap_err
  );

  modport slave (
    input  in_valid, in_last, q, out_ready,
    output in_ready, out_valid, out_sum, tap_err
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO: the head entry is visible on data_o whenever
// the FIFO is not empty. Storage is not reset; data_o reads zero while empty.
module sync_fifo_fwft
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW   = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CNTW = clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  // A pop frees the slot in the same cycle, so push-and-pop while full is fine.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Next pointers and occupancy from this cycle's push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = ptr_inc(wr_q);
    if (do_pop)  rd_d = ptr_inc(rd_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Entry storage; written only, never cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fir_tap_accumulator.sv
// Sums the multiplier products of one output sample's taps. Valid/last tags
// ride a delay line matched to the multiplier latency; finished sums go into
// a small FWFT FIFO whose slots are reserved by credits at issue time, so the
// non-stallable multiplier pipeline never meets a full FIFO.
module fir_tap_accumulator
  import fir_pkg::*;
#(
  parameter int BITWIDTH_INPUT = DEFAULT_BITWIDTH_INPUT,
  parameter int NUM_TAPS       = 8,
  parameter int MUL_LATENCY    = mul_latency(BITWIDTH_INPUT),
  parameter int FIFO_DEPTH     = 2
) (
  input logic                  clk,
  input logic                  rstn,
  fir_tap_accumulator_if.slave bus
);
  localparam int ACC_WIDTH = acc_width(BITWIDTH_INPUT, NUM_TAPS);
  localparam int TCW       = clog2(NUM_TAPS) + 1;
  localparam int CW        = clog2(FIFO_DEPTH) + 1;
  localparam logic [TCW-1:0] TC_MAX  = TCW'(NUM_TAPS);
  localparam logic [TCW-1:0] TC_LAST = TCW'(NUM_TAPS - 1);
  localparam logic [CW-1:0]  CR_FULL = CW'(FIFO_DEPTH);

  tag_t                 tag_q [MUL_LATENCY];
  tag_t                 tag_in_d;
  logic                 acc_in, p_valid, p_last;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic                 first_q, first_d;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        credit_q, credit_d;
  logic                 push, pop;
  logic                 fifo_empty, fifo_full;
  logic [ACC_WIDTH-1:0] fifo_data;

  assign acc_in   = bus.in_valid & bus.in_ready;
  assign tag_in_d = '{valid: acc_in, last: acc_in & bus.in_last};
  assign p_valid  = tag_q[MUL_LATENCY-1].valid;
  assign p_last   = tag_q[MUL_LATENCY-1].last;
  assign pop      = ~fifo_empty & bus.out_ready;

  assign bus.in_ready  = (credit_q != '0);
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_sum   = fifo_data;
  assign bus.tap_err   = err_q;

  // Tag delay line; clearing it on reset drops products still in the multiplier.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < MUL_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in_d;
      for (int i = 1; i < MUL_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Running sum; the first tap of a group restarts from zero via 'first'.
  always_comb begin
    sum     = (first_q ? '0 : acc_q) + ACC_WIDTH'(bus.q);
    acc_d   = acc_q;
    first_d = first_q;
    push    = 1'b0;
    if (p_valid) begin
      first_d = p_last;
      push    = p_last;
      acc_d   = p_last ? '0 : sum;
    end
  end

  // Tap count per group and the sticky count-error flag.
  always_comb begin
    tcnt_d = tcnt_q;
    err_d  = err_q;
    if (p_valid) begin
      if (p_last) begin
        tcnt_d = '0;
        if (tcnt_q != TC_LAST) err_d = 1'b1;
      end else begin
        if (tcnt_q != TC_MAX)  tcnt_d = tcnt_q + 1'b1;
        if (tcnt_q == TC_LAST) err_d  = 1'b1;
      end
    end
  end

  // Credits: a slot is reserved when a group's last tap is issued.
  always_comb begin
    credit_d = credit_q;
    case ({acc_in & bus.in_last, pop})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  // Accumulator, counter, flag and credit registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q    <= '0;
      first_q  <= 1'b1;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      credit_q <= CR_FULL;
    end else begin
      acc_q    <= acc_d;
      first_q  <= first_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (sum),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Credit reservation makes a push into a full, non-draining FIFO impossible.
  push_while_full_a : assert property (@(posedge clk) disable iff (!rstn)
    !(push && fifo_full && !pop));
endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Bench for fir_tap_accumulator: a behavioural multiplier feeds q, and a
// queue-based model of finished sums predicts outputs every cycle.
module tb_fir_tap_accumulator;
  localparam int NT  = 8;
  localparam int L   = 7;
  localparam int FD  = 2;
  localparam int INF = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [31:0] mpipe [L];

  always #5 clk = ~clk;

  fir_tap_accumulator_if #(.BITWIDTH_INPUT(16), .NUM_TAPS(NT)) bus ();

  fir_tap_accumulator #(
    .BITWIDTH_INPUT (16),
    .NUM_TAPS       (NT),
    .MUL_LATENCY    (L),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Behavioural fixed-latency multiplier.
  always @(posedge clk) begin
    mpipe[0] <= 32'(a) * 32'(b);
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.q = mpipe[L-1];

  typedef struct {
    longint unsigned sum;
    int              avail;
  } pend_t;

  typedef struct {
    int              n;
    int              a0;
    int              astep;
    int              bv;
    longint unsigned sum;
    bit              err;
  } vec_t;

  pend_t           pq[$];
  longint unsigned got[$];
  int              cyc = 0, outstanding = 0, gcnt = 0, err_cyc = INF;
  longint unsigned gsum = 0;
  int              n_cmp = 0, n_fail = 0;
  bit              chk_en = 1'b0;
  bit              obs_ov, obs_err, obs_rdy;
  longint unsigned obs_sum;
  int              obs_cyc;

  function automatic bit exp_ready();
    return outstanding < FD;
  endfunction

  function automatic bit exp_valid();
    return (pq.size() > 0) && (pq[0].avail <= cyc);
  endfunction

  function automatic bit rnd_ordy();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s cycle %0d: wait bound expired", name, cyc);
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit v, input bit l, input logic [15:0] av, input logic [15:0] bv,
                      input bit ordy, input bit rn);
    bit              accept, pop;
    longint unsigned p;
    @(negedge clk);
    obs_ov  = bus.out_valid;
    obs_sum = 64'(bus.out_sum);
    obs_err = bus.tap_err;
    obs_rdy = bus.in_ready;
    obs_cyc = cyc;
    if (chk_en) begin
      check("in_ready", 64'(obs_rdy), 64'(exp_ready()));
      check("out_valid", 64'(obs_ov), 64'(exp_valid()));
      if (exp_valid()) check("out_sum", obs_sum, pq[0].sum);
      check("tap_err", 64'(obs_err), 64'(cyc >= err_cyc));
    end
    if (obs_ov && ordy) got.push_back(obs_sum);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = ordy;
    a    = av;
    b    = bv;
    rstn = rn;
    if (!rn) begin
      pq.delete();
      outstanding = 0;
      gcnt        = 0;
      gsum        = 0;
      err_cyc     = INF;
    end else begin
      pop    = exp_valid() && ordy;
      accept = v && exp_ready();
      if (accept) begin
        p    = 64'(av) * 64'(bv);
        gsum = gsum + p;
        if (l) begin
          if (gcnt != NT - 1 && cyc + L + 1 < err_cyc) err_cyc = cyc + L + 1;
          pq.push_back(pend_t'{sum: gsum, avail: cyc + L + 1});
          outstanding++;
          gsum = 0;
          gcnt = 0;
        end else begin
          if (gcnt == NT - 1 && cyc + L + 1 < err_cyc) err_cyc = cyc + L + 1;
          gcnt++;
        end
      end
      if (pop) begin
        void'(pq.pop_front());
        outstanding--;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, ordy, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // Values visible just after the reset edge.
  task automatic rst_check();
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum", 64'(bus.out_sum), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_tap_err", 64'(bus.tap_err), 64'd0);
  endtask

  task automatic issue_group(input int n, input int a0, input int astep, input int bv,
                             input bit ordy, output int t_last);
    int w;
    w = 0;
    t_last = -1;
    while (!exp_ready() && w < 50) begin
      step(1'b0, 1'b0, '0, '0, ordy, 1'b1);
      w++;
    end
    if (!exp_ready()) bound_fail("group_wait");
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) t_last = cyc;
      step(1'b1, k == n - 1, 16'(a0 + k * astep), 16'(bv), ordy, 1'b1);
    end
  endtask

  task automatic check_got(input string name, input int idx, input longint unsigned exp);
    check(name, (idx < got.size()) ? got[idx] : 64'hDEAD_DEAD, exp);
  endtask

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_last, seen;
    longint unsigned seen_sum;

    tbl[0] = '{n: 8, a0: 1,          astep: 1,   bv: 1,          sum: 64'd36,          err: 1'b0};
    tbl[1] = '{n: 8, a0: 32'hFFFF,   astep: 0,   bv: 32'hFFFF,   sum: 64'h7_FFF0_0008, err: 1'b0};
    tbl[2] = '{n: 8, a0: 10,         astep: 0,   bv: 1,          sum: 64'd80,          err: 1'b0};
    tbl[3] = '{n: 8, a0: 100,        astep: 100, bv: 3,          sum: 64'd10800,       err: 1'b0};
    tbl[4] = '{n: 7, a0: 1,          astep: 1,   bv: 1,          sum: 64'd28,          err: 1'b1};
    tbl[5] = '{n: 1, a0: 5,          astep: 0,   bv: 7,          sum: 64'd35,          err: 1'b1};
    tbl[6] = '{n: 9, a0: 1,          astep: 1,   bv: 2,          sum: 64'd90,          err: 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();
    do_reset();
    chk_en = 1'b1;
    rst_check();

    // Single-group vectors: sum, exact latency and error flag.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      rst_check();
      issue_group(tbl[i].n, tbl[i].a0, tbl[i].astep, tbl[i].bv, 1'b1, t_last);
      seen = -1;
      seen_sum = '0;
      for (int c = 0; c < L + 6; c++) begin
        idle(1, 1'b1);
        if (obs_ov && seen < 0) begin
          seen     = obs_cyc;
          seen_sum = obs_sum;
        end
      end
      check($sformatf("tbl%0d_latency", i), 64'(seen - t_last), 64'(L + 1));
      check($sformatf("tbl%0d_sum", i), seen_sum, tbl[i].sum);
      check($sformatf("tbl%0d_err", i), 64'(obs_err), 64'(tbl[i].err));
    end

    // Backpressure: two sums fill the FIFO, the third group waits for drain.
    do_reset();
    rst_check();
    got.delete();
    issue_group(8, 1, 1, 1, 1'b0, t_last);
    issue_group(8, 2, 0, 3, 1'b0, t_last);
    idle(L + 4, 1'b0);
    check("bp_in_ready_low", 64'(obs_rdy), 64'd0);
    check("bp_head_valid", 64'(obs_ov), 64'd1);
    check("bp_head_hold", obs_sum, 64'd36);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'd50, 16'd50, 1'b0, 1'b1);
    idle(3, 1'b0);
    check("bp_head_still", obs_sum, 64'd36);
    idle(4, 1'b1);
    check("bp_drain_cnt", 64'(got.size()), 64'd2);
    check_got("bp_drain0", 0, 64'd36);
    check_got("bp_drain1", 1, 64'd48);
    issue_group(8, 7, 0, 1, 1'b1, t_last);
    idle(L + 4, 1'b1);
    check_got("bp_third", 2, 64'd56);

    // Back-to-back groups with no bubble.
    do_reset();
    got.delete();
    issue_group(8, 1, 1, 1, 1'b1, t_last);
    issue_group(8, 10, 0, 1, 1'b1, t_last);
    idle(L + 4, 1'b1);
    check("b2b_cnt", 64'(got.size()), 64'd2);
    check_got("b2b_first", 0, 64'd36);
    check_got("b2b_second", 1, 64'd80);

    // Short group raises the sticky error; a good group still sums right.
    do_reset();
    got.delete();
    issue_group(7, 1, 1, 1, 1'b1, t_last);
    issue_group(8, 1, 1, 1, 1'b1, t_last);
    idle(L + 4, 1'b1);
    check_got("terr_short_sum", 0, 64'd28);
    check_got("terr_good_sum", 1, 64'd36);
    idle(10, 1'b1);
    check("terr_sticky", 64'(obs_err), 64'd1);
    do_reset();
    rst_check();

    // Reset in the middle of a group discards it.
    got.delete();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'(k + 1), 16'd9, 1'b1, 1'b1);
    do_reset();
    rst_check();
    idle(L + 2, 1'b1);
    check("rmid_no_output", 64'(got.size()), 64'd0);
    issue_group(8, 2, 2, 1, 1'b1, t_last);
    idle(L + 4, 1'b1);
    check("rmid_cnt", 64'(got.size()), 64'd1);
    check_got("rmid_sum", 0, 64'd72);
    check("rmid_err", 64'(obs_err), 64'd0);

    // Randomized groups, gaps, backpressure and occasional resets.
    for (int g = 0; g < 80; g++) begin
      int  n, w;
      bit  aborted;
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 10) : NT;
      for (int k = 0; k < $urandom_range(0, 2); k++) step(1'b0, 1'b0, '0, '0, rnd_ordy(), 1'b1);
      w = 0;
      while (!exp_ready() && w < 60) begin
        step(1'b0, 1'b0, '0, '0, rnd_ordy(), 1'b1);
        w++;
      end
      if (!exp_ready()) bound_fail("rnd_wait");
      aborted = 1'b0;
      for (int k = 0; k < n && !aborted; k++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
          aborted = 1'b1;
        end else begin
          step(1'b1, k == n - 1,
               ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
               ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
               rnd_ordy(), 1'b1);
        end
      end
    end
    idle(L + 10, 1'b1);
    check("rnd_drained", 64'(pq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
